// File: rtl/encoder_trigger_scheduler.sv
// Encoder-driven trigger scheduler for line-scan acquisition and valve ejection.
//
// The quadrature encoder is synchronised and decoded into forward and reverse
// steps. These steps maintain a signed position count. While running, forward
// steps are divided down into camera line-trigger events, and camera events are
// divided down again into valve events. Reverse steps build up a rewind backlog.
// The same number of forward steps must be replayed before the camera divider
// advances again, so conveyor jitter cannot re-trigger the same line.
//
// Ports:
//   ACLK, ARESET         system clock, asynchronous active-high reset
//   enc_a, enc_b         raw encoder phases (asynchronous to ACLK)
//   cmd_start/stop/clear single-cycle command pulses from the register bank
//   cfg_cam_div          forward steps per camera trigger (0 acts as 1)
//   cfg_valve_div        camera triggers per valve trigger (0 acts as 1)
//   cfg_pulse_len        trigger high time in ACLK cycles (0 acts as 1)
//   cam_trig, valve_trig trigger pulse outputs
//   position             signed two's-complement encoder position
//   cam_count            camera triggers issued since the last clear
//   running              scheduler is not idle
//   err_illegal          sticky: both encoder phases changed in one cycle
//   err_overrun          sticky: trigger event arrived while its pulse was high
//
// Event latency: sync chain (SYNC_STAGES) + step register + event register.
// cam_trig therefore rises SYNC_STAGES+2 edges after the sampling edge.
module encoder_trigger_scheduler #(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned DIV_W       = 16,
  parameter int unsigned PULSE_W     = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic               ACLK,
  input  logic               ARESET,
  input  logic               enc_a,
  input  logic               enc_b,
  input  logic               cmd_start,
  input  logic               cmd_stop,
  input  logic               cmd_clear,
  input  logic [DIV_W-1:0]   cfg_cam_div,
  input  logic [DIV_W-1:0]   cfg_valve_div,
  input  logic [PULSE_W-1:0] cfg_pulse_len,
  output logic               cam_trig,
  output logic               valve_trig,
  output logic [CNT_W-1:0]   position,
  output logic [CNT_W-1:0]   cam_count,
  output logic               running,
  output logic               err_illegal,
  output logic               err_overrun
);

  localparam logic [CNT_W-1:0]   CntOne   = CNT_W'(1);
  localparam logic [DIV_W-1:0]   DivOne   = DIV_W'(1);
  localparam logic [PULSE_W-1:0] PulseOne = PULSE_W'(1);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  // Next {a,b} in the forward direction: 00 -> 01 -> 11 -> 10 -> 00.
  function automatic logic [1:0] fwd_of(input logic [1:0] s);
    logic [1:0] r;
    unique case (s)
      2'b00:   r = 2'b01;
      2'b01:   r = 2'b11;
      2'b11:   r = 2'b10;
      default: r = 2'b00;
    endcase
    return r;
  endfunction

  logic [SYNC_STAGES-1:0] sync_a_q, sync_b_q;
  logic [1:0]             cur_ab, prev_q;
  logic                   dec_fwd, dec_rev, dec_ill;
  logic                   step_fwd_q, step_rev_q, step_ill_q;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     position_q, position_d;
  logic [CNT_W-1:0]     cam_count_q, cam_count_d;
  logic [DIV_W-1:0]     step_cnt_q, step_cnt_d, step_cnt_inc;
  logic [DIV_W-1:0]     cam_cnt_div_q, cam_cnt_div_d, cam_cnt_div_inc;
  logic [DIV_W-1:0]     rewind_q, rewind_d;
  logic [DIV_W-1:0]     cam_div_q, cam_div_d;
  logic [DIV_W-1:0]     valve_div_q, valve_div_d;
  logic [PULSE_W-1:0]   pulse_len_q, pulse_len_d;
  logic [PULSE_W-1:0]   cam_pcnt_q, cam_pcnt_d;
  logic [PULSE_W-1:0]   valve_pcnt_q, valve_pcnt_d;
  logic                 cam_evt_q, cam_evt_d;
  logic                 valve_evt_q, valve_evt_d;
  logic                 err_illegal_q, err_illegal_d;
  logic                 err_overrun_q, err_overrun_d;

  assign cur_ab  = {sync_a_q[SYNC_STAGES-1], sync_b_q[SYNC_STAGES-1]};
  assign dec_fwd = (cur_ab == fwd_of(prev_q));
  assign dec_rev = (prev_q == fwd_of(cur_ab));
  assign dec_ill = ((cur_ab ^ prev_q) == 2'b11);

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      sync_a_q   <= '0;
      sync_b_q   <= '0;
      prev_q     <= '0;
      step_fwd_q <= 1'b0;
      step_rev_q <= 1'b0;
      step_ill_q <= 1'b0;
    end else begin
      sync_a_q   <= {sync_a_q[SYNC_STAGES-2:0], enc_a};
      sync_b_q   <= {sync_b_q[SYNC_STAGES-2:0], enc_b};
      prev_q     <= cur_ab;
      step_fwd_q <= dec_fwd;
      step_rev_q <= dec_rev;
      step_ill_q <= dec_ill;
    end
  end

  assign step_cnt_inc    = step_cnt_q + DivOne;
  assign cam_cnt_div_inc = cam_cnt_div_q + DivOne;

  always_comb begin
    state_d       = state_q;
    position_d    = position_q;
    cam_count_d   = cam_count_q;
    step_cnt_d    = step_cnt_q;
    cam_cnt_div_d = cam_cnt_div_q;
    rewind_d      = rewind_q;
    cam_div_d     = cam_div_q;
    valve_div_d   = valve_div_q;
    pulse_len_d   = pulse_len_q;
    cam_pcnt_d    = cam_pcnt_q;
    valve_pcnt_d  = valve_pcnt_q;
    cam_evt_d     = 1'b0;
    valve_evt_d   = 1'b0;
    err_illegal_d = err_illegal_q;
    err_overrun_d = err_overrun_q;

    // Pulse generators: count down; an event only loads an idle generator.
    if (cam_pcnt_q != '0) cam_pcnt_d = cam_pcnt_q - PulseOne;
    if (valve_pcnt_q != '0) valve_pcnt_d = valve_pcnt_q - PulseOne;
    if (cam_evt_q) begin
      if (cam_pcnt_q != '0) err_overrun_d = 1'b1;
      else                  cam_pcnt_d    = pulse_len_q;
    end
    if (valve_evt_q) begin
      if (valve_pcnt_q != '0) err_overrun_d = 1'b1;
      else                    valve_pcnt_d  = pulse_len_q;
    end

    // Position tracks the encoder regardless of scheduler state.
    if (step_ill_q) err_illegal_d = 1'b1;
    if (step_fwd_q) position_d = position_q + CntOne;
    if (step_rev_q) position_d = position_q - CntOne;

    if (state_q == StRun && !cmd_stop) begin
      if (step_rev_q && rewind_q != '1) rewind_d = rewind_q + DivOne;
      if (step_fwd_q) begin
        if (rewind_q != '0) begin
          // Replaying ground already covered before a reverse excursion.
          rewind_d = rewind_q - DivOne;
        end else if (step_cnt_inc == cam_div_q) begin
          step_cnt_d  = '0;
          cam_evt_d   = 1'b1;
          cam_count_d = cam_count_q + CntOne;
          if (cam_cnt_div_inc == valve_div_q) begin
            cam_cnt_div_d = '0;
            valve_evt_d   = 1'b1;
          end else begin
            cam_cnt_div_d = cam_cnt_div_inc;
          end
        end else begin
          step_cnt_d = step_cnt_inc;
        end
      end
    end

    unique case (state_q)
      StIdle: begin
        if (cmd_start && !cmd_stop) begin
          state_d       = StRun;
          cam_div_d     = (cfg_cam_div == '0) ? DivOne : cfg_cam_div;
          valve_div_d   = (cfg_valve_div == '0) ? DivOne : cfg_valve_div;
          pulse_len_d   = (cfg_pulse_len == '0) ? PulseOne : cfg_pulse_len;
          step_cnt_d    = '0;
          cam_cnt_div_d = '0;
          rewind_d      = '0;
        end
      end
      StRun: begin
        if (cmd_stop) state_d = StDrain;
      end
      StDrain: begin
        // Leave together with the falling edge of the last pulse.
        if (cam_pcnt_d == '0 && valve_pcnt_d == '0) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Clear discards the step being processed but leaves pulses and state alone.
    if (cmd_clear) begin
      position_d    = '0;
      cam_count_d   = '0;
      step_cnt_d    = '0;
      cam_cnt_div_d = '0;
      rewind_d      = '0;
      err_illegal_d = 1'b0;
      err_overrun_d = 1'b0;
      cam_evt_d     = 1'b0;
      valve_evt_d   = 1'b0;
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q       <= StIdle;
      position_q    <= '0;
      cam_count_q   <= '0;
      step_cnt_q    <= '0;
      cam_cnt_div_q <= '0;
      rewind_q      <= '0;
      cam_div_q     <= '0;
      valve_div_q   <= '0;
      pulse_len_q   <= '0;
      cam_pcnt_q    <= '0;
      valve_pcnt_q  <= '0;
      cam_evt_q     <= 1'b0;
      valve_evt_q   <= 1'b0;
      err_illegal_q <= 1'b0;
      err_overrun_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      position_q    <= position_d;
      cam_count_q   <= cam_count_d;
      step_cnt_q    <= step_cnt_d;
      cam_cnt_div_q <= cam_cnt_div_d;
      rewind_q      <= rewind_d;
      cam_div_q     <= cam_div_d;
      valve_div_q   <= valve_div_d;
      pulse_len_q   <= pulse_len_d;
      cam_pcnt_q    <= cam_pcnt_d;
      valve_pcnt_q  <= valve_pcnt_d;
      cam_evt_q     <= cam_evt_d;
      valve_evt_q   <= valve_evt_d;
      err_illegal_q <= err_illegal_d;
      err_overrun_q <= err_overrun_d;
    end
  end

  assign cam_trig    = (cam_pcnt_q != '0);
  assign valve_trig  = (valve_pcnt_q != '0);
  assign position    = position_q;
  assign cam_count   = cam_count_q;
  assign running     = (state_q != StIdle);
  assign err_illegal = err_illegal_q;
  assign err_overrun = err_overrun_q;

endmodule

// File: tb/tb_encoder_trigger_scheduler.sv
// Directed bench for encoder_trigger_scheduler (default parameters).
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_encoder_trigger_scheduler;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        enc_a, enc_b;
  logic        cmd_start, cmd_stop, cmd_clear;
  logic [15:0] cfg_cam_div, cfg_valve_div, cfg_pulse_len;
  logic        cam_trig, valve_trig, running, err_illegal, err_overrun;
  logic [31:0] position, cam_count;

  int vectors     = 0;
  int miscompares = 0;

  // Trigger activity, sampled before each rising edge.
  int   cam_rises = 0, cam_high = 0, valve_rises = 0, valve_high = 0, both_rises = 0;
  logic cam_prev = 1'b0, valve_prev = 1'b0;

  int enc_idx = 0;
  int r0, h0, vr0, vh0, b0;

  encoder_trigger_scheduler dut (
    .ACLK          (ACLK),
    .ARESET        (ARESET),
    .enc_a         (enc_a),
    .enc_b         (enc_b),
    .cmd_start     (cmd_start),
    .cmd_stop      (cmd_stop),
    .cmd_clear     (cmd_clear),
    .cfg_cam_div   (cfg_cam_div),
    .cfg_valve_div (cfg_valve_div),
    .cfg_pulse_len (cfg_pulse_len),
    .cam_trig      (cam_trig),
    .valve_trig    (valve_trig),
    .position      (position),
    .cam_count     (cam_count),
    .running       (running),
    .err_illegal   (err_illegal),
    .err_overrun   (err_overrun)
  );

  always #5 ACLK = ~ACLK;

  always @(posedge ACLK) begin
    if (cam_trig) cam_high++;
    if (valve_trig) valve_high++;
    if (cam_trig && !cam_prev) cam_rises++;
    if (valve_trig && !valve_prev) valve_rises++;
    if (cam_trig && !cam_prev && valve_trig && !valve_prev) both_rises++;
    cam_prev   = cam_trig;
    valve_prev = valve_trig;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge ACLK);
  endtask

  // Gray order of {a,b}: 00, 01, 11, 10.
  task automatic drive_enc();
    case (enc_idx)
      0:       {enc_a, enc_b} = 2'b00;
      1:       {enc_a, enc_b} = 2'b01;
      2:       {enc_a, enc_b} = 2'b11;
      default: {enc_a, enc_b} = 2'b10;
    endcase
  endtask

  task automatic fwd(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      enc_idx = (enc_idx + 1) % 4;
      drive_enc();
      tick(gap);
    end
  endtask

  task automatic rev(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      enc_idx = (enc_idx + 3) % 4;
      drive_enc();
      tick(gap);
    end
  endtask

  task automatic do_start();
    cmd_start = 1'b1;
    tick(1);
    cmd_start = 1'b0;
  endtask

  task automatic do_stop();
    cmd_stop = 1'b1;
    tick(1);
    cmd_stop = 1'b0;
  endtask

  task automatic do_clear_start();
    cmd_clear = 1'b1;
    cmd_start = 1'b1;
    tick(1);
    cmd_clear = 1'b0;
    cmd_start = 1'b0;
  endtask

  task automatic snap();
    r0  = cam_rises;
    h0  = cam_high;
    vr0 = valve_rises;
    vh0 = valve_high;
    b0  = both_rises;
  endtask

  initial begin
    ARESET        = 1'b1;
    enc_a         = 1'b0;
    enc_b         = 1'b0;
    cmd_start     = 1'b0;
    cmd_stop      = 1'b0;
    cmd_clear     = 1'b0;
    cfg_cam_div   = 16'd4;
    cfg_valve_div = 16'd3;
    cfg_pulse_len = 16'd5;
    tick(2);
    check("rst_cam_trig", 64'(cam_trig), 64'd0);
    check("rst_valve_trig", 64'(valve_trig), 64'd0);
    check("rst_position", 64'(position), 64'd0);
    check("rst_cam_count", 64'(cam_count), 64'd0);
    check("rst_running", 64'(running), 64'd0);
    check("rst_err_illegal", 64'(err_illegal), 64'd0);
    check("rst_err_overrun", 64'(err_overrun), 64'd0);
    ARESET = 1'b0;
    tick(2);

    // Basic division: cam_div 4, valve_div 3, pulse_len 5, 12 forward steps.
    do_start();
    check("t1_running", 64'(running), 64'd1);
    snap();
    for (int s = 1; s <= 12; s++) begin
      fwd(1, 10);
      if (s == 3) check("t1_rises_step3", 64'(cam_rises - r0), 64'd0);
      if (s == 4) check("t1_rises_step4", 64'(cam_rises - r0), 64'd1);
      if (s == 8) begin
        check("t1_rises_step8", 64'(cam_rises - r0), 64'd2);
        check("t1_valve_step8", 64'(valve_rises - vr0), 64'd0);
      end
    end
    check("t1_cam_rises", 64'(cam_rises - r0), 64'd3);
    check("t1_cam_high", 64'(cam_high - h0), 64'd15);
    check("t1_valve_rises", 64'(valve_rises - vr0), 64'd1);
    check("t1_valve_high", 64'(valve_high - vh0), 64'd5);
    check("t1_valve_with_cam", 64'(both_rises - b0), 64'd1);
    check("t1_position", 64'(position), 64'd12);
    check("t1_cam_count", 64'(cam_count), 64'd3);

    // Latency: cam_div 1, rise exactly 4 edges after the sampling edge.
    do_stop();
    tick(3);
    check("t2_idle", 64'(running), 64'd0);
    cfg_cam_div = 16'd1;
    do_start();
    enc_idx = (enc_idx + 1) % 4;
    drive_enc();
    tick(4);
    check("t2_before_edge4", 64'(cam_trig), 64'd0);
    tick(1);
    check("t2_at_edge4", 64'(cam_trig), 64'd1);
    tick(10);
    check("t2_position", 64'(position), 64'd13);
    check("t2_cam_count", 64'(cam_count), 64'd4);

    // Jitter with cam_div 2, entered via clear+start from idle.
    do_stop();
    tick(3);
    cfg_cam_div = 16'd2;
    do_clear_start();
    check("t3_clr_position", 64'(position), 64'd0);
    check("t3_clr_running", 64'(running), 64'd1);
    snap();
    fwd(1, 10);
    rev(3, 10);
    fwd(3, 10);
    check("t3_no_trig_in_backlog", 64'(cam_rises - r0), 64'd0);
    // After the backlog drains, step_cnt is 1 from the first step; the next
    // fresh forward step completes the divide-by-2.
    fwd(1, 10);
    check("t3_trig_fresh_step", 64'(cam_rises - r0), 64'd1);
    fwd(1, 10);
    check("t3_one_trig_only", 64'(cam_rises - r0), 64'd1);
    check("t3_position", 64'(position), 64'd3);
    fwd(1, 10);
    check("t3_rewind_empty", 64'(cam_rises - r0), 64'd2);
    check("t3_cam_count", 64'(cam_count), 64'd2);

    // Overrun: cam_div 1, pulse_len 10, steps 4 cycles apart.
    do_stop();
    tick(3);
    cfg_cam_div   = 16'd1;
    cfg_valve_div = 16'd1;
    cfg_pulse_len = 16'd10;
    do_clear_start();
    snap();
    fwd(3, 4);
    tick(20);
    check("t4_err_overrun", 64'(err_overrun), 64'd1);
    check("t4_cam_count", 64'(cam_count), 64'd3);
    check("t4_cam_rises", 64'(cam_rises - r0), 64'd1);
    check("t4_cam_high", 64'(cam_high - h0), 64'd10);
    check("t4_position", 64'(position), 64'd3);

    // Illegal transition: both phases toggle together.
    enc_idx = (enc_idx + 2) % 4;
    drive_enc();
    tick(6);
    check("t5_err_illegal", 64'(err_illegal), 64'd1);
    check("t5_position_held", 64'(position), 64'd3);
    cmd_clear = 1'b1;
    tick(1);
    cmd_clear = 1'b0;
    check("t5_clr_err_illegal", 64'(err_illegal), 64'd0);
    check("t5_clr_err_overrun", 64'(err_overrun), 64'd0);
    check("t5_clr_position", 64'(position), 64'd0);
    check("t5_clr_keeps_run", 64'(running), 64'd1);

    // Stop two cycles into a 5-cycle pulse.
    do_stop();
    tick(3);
    cfg_pulse_len = 16'd5;
    do_start();
    enc_idx = (enc_idx + 1) % 4;
    drive_enc();
    tick(5);
    check("t6_pulse_up", 64'(cam_trig), 64'd1);
    tick(1);
    cmd_stop = 1'b1;
    tick(1);
    cmd_stop = 1'b0;
    check("t6_drain_1", 64'(running), 64'd1);
    tick(1);
    check("t6_drain_2", 64'(running), 64'd1);
    tick(1);
    check("t6_drain_3", 64'(running), 64'd1);
    check("t6_pulse_still_up", 64'(cam_trig), 64'd1);
    tick(1);
    check("t6_idle", 64'(running), 64'd0);
    check("t6_pulse_done", 64'(cam_trig), 64'd0);
    snap();
    fwd(2, 10);
    check("t6_no_trig_idle", 64'(cam_rises - r0), 64'd0);
    check("t6_position_idle", 64'(position), 64'd3);

    // Asynchronous reset in the middle of a pulse.
    do_start();
    enc_idx = (enc_idx + 1) % 4;
    drive_enc();
    tick(6);
    check("t7_pulse_up", 64'(cam_trig), 64'd1);
    #2 ARESET = 1'b1;
    #1;
    check("t7_rst_cam_trig", 64'(cam_trig), 64'd0);
    check("t7_rst_valve_trig", 64'(valve_trig), 64'd0);
    check("t7_rst_running", 64'(running), 64'd0);
    check("t7_rst_position", 64'(position), 64'd0);
    tick(2);
    ARESET = 1'b0;
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
